// File: rtl/mirror_line_ctrl.sv
// Ping-pong address/bank scheduler for the two line-buffer banks ahead of the column-mirror stage.
// One bank is written while the previously completed line is read back, reversed or straight.
module mirror_line_ctrl #(
  parameter int LINE_W = 640,
  parameter int AW     = 10,
  parameter int LC_W   = 12
) (
  input  logic            iCCD_PIXCLK,
  input  logic            iRST_N,
  input  logic            iCCD_DVAL,
  input  logic            iCCD_FVAL,
  input  logic            iMIRROR_EN,
  output logic            oWR_EN,
  output logic            oWR_BANK,
  output logic [AW-1:0]   oWR_ADDR,
  output logic            oRD_BANK,
  output logic [AW-1:0]   oRD_ADDR,
  output logic            oDVAL,
  output logic [LC_W-1:0] oLINE_CNT,
  output logic            oOVF
);

  localparam logic [AW-1:0] LAST = AW'(LINE_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t          state_r;
  logic            fval_r;
  logic [AW-1:0]   wr_cnt_r;
  logic            wr_bank_r;
  logic            rd_bank_r;
  logic [1:0]      full_r;
  logic [AW-1:0]   rd_cnt_r;
  logic            mir_r;
  logic [AW-1:0]   rd_addr_r;
  logic            dval_r;
  logic [LC_W-1:0] line_cnt_r;
  logic            ovf_r;

  logic            frame_start_s;
  logic            wr_last_s;
  logic            rd_last_s;
  logic            drop_s;
  logic [1:0]      full_clr_s;
  logic [1:0]      full_next_s;
  logic [AW-1:0]   rd_nxt_s;

  assign oWR_EN        = iCCD_DVAL & iCCD_FVAL;
  assign frame_start_s = iCCD_FVAL & ~fval_r;
  assign wr_last_s     = oWR_EN & (wr_cnt_r == LAST);
  assign rd_last_s     = (state_r == READ) & (rd_cnt_r == LAST);
  assign rd_nxt_s      = rd_cnt_r + AW'(1);

  // Bank occupancy: a read finishing on a bank frees it before a completing write tests it.
  always_comb begin
    full_clr_s = full_r;
    if (rd_last_s) begin
      full_clr_s[rd_bank_r] = 1'b0;
    end else begin
      full_clr_s = full_r;
    end
    drop_s      = wr_last_s & full_clr_s[wr_bank_r];
    full_next_s = full_clr_s;
    if (wr_last_s && !drop_s) begin
      full_next_s[wr_bank_r] = 1'b1;
    end else begin
      full_next_s = full_clr_s;
    end
  end

  // Previous FVAL sample for frame-start edge detection.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_r <= 1'b0;
    end else begin
      fval_r <= iCCD_FVAL;
    end
  end

  // Write side: pixel counter, bank toggle and sticky overflow when a line lands on a full bank.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_cnt_r  <= {AW{1'b0}};
      wr_bank_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (frame_start_s) begin
      wr_cnt_r  <= {AW{1'b0}};
      wr_bank_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (wr_last_s) begin
      wr_cnt_r  <= {AW{1'b0}};
      wr_bank_r <= ~wr_bank_r;
      ovf_r     <= ovf_r | drop_s;
    end else if (oWR_EN) begin
      wr_cnt_r  <= wr_cnt_r + AW'(1);
    end
  end

  // Full flags per bank; a partial line never sets one and frame start discards both.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      full_r <= 2'b00;
    end else if (frame_start_s) begin
      full_r <= 2'b00;
    end else begin
      full_r <= full_next_s;
    end
  end

  // Read FSM: mirror mode is latched at line start so mid-line changes wait for the next line.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r    <= IDLE;
      rd_cnt_r   <= {AW{1'b0}};
      rd_bank_r  <= 1'b0;
      mir_r      <= 1'b0;
      rd_addr_r  <= {AW{1'b0}};
      dval_r     <= 1'b0;
      line_cnt_r <= {LC_W{1'b0}};
    end else begin
      dval_r <= (state_r == READ);
      if (frame_start_s) begin
        state_r    <= IDLE;
        rd_cnt_r   <= {AW{1'b0}};
        rd_bank_r  <= 1'b0;
        rd_addr_r  <= {AW{1'b0}};
        line_cnt_r <= {LC_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            if (full_r[rd_bank_r]) begin
              state_r   <= READ;
              rd_cnt_r  <= {AW{1'b0}};
              mir_r     <= iMIRROR_EN;
              rd_addr_r <= iMIRROR_EN ? LAST : {AW{1'b0}};
            end
          end
          READ: begin
            if (rd_last_s) begin
              state_r    <= IDLE;
              rd_cnt_r   <= {AW{1'b0}};
              rd_bank_r  <= ~rd_bank_r;
              rd_addr_r  <= {AW{1'b0}};
              line_cnt_r <= line_cnt_r + LC_W'(1);
            end else begin
              rd_cnt_r  <= rd_nxt_s;
              rd_addr_r <= mir_r ? (LAST - rd_nxt_s) : rd_nxt_s;
            end
          end
          default: begin
            state_r   <= IDLE;
            rd_addr_r <= {AW{1'b0}};
          end
        endcase
      end
    end
  end

  assign oWR_BANK  = wr_bank_r;
  assign oWR_ADDR  = wr_cnt_r;
  assign oRD_BANK  = rd_bank_r;
  assign oRD_ADDR  = rd_addr_r;
  assign oDVAL     = dval_r;
  assign oLINE_CNT = line_cnt_r;
  assign oOVF      = ovf_r;

endmodule

// File: tb/tb_mirror_line_ctrl.sv
// Bench for mirror_line_ctrl with LINE_W = 8: cycle table for one mirrored line, then
// scoreboarded sequences driven through a behavioural dual-bank RAM with 1-cycle read.
module tb_mirror_line_ctrl;

  localparam int LW  = 8;
  localparam int AWT = 3;
  localparam int LCW = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dval;
  logic            fval;
  logic            mir;
  logic            wr_en;
  logic            wr_bank;
  logic [AWT-1:0]  wr_addr;
  logic            rd_bank;
  logic [AWT-1:0]  rd_addr;
  logic            odval;
  logic [LCW-1:0]  line_cnt;
  logic            ovf;

  logic [7:0]      pix;
  logic [7:0]      mem [16];
  logic [7:0]      q;
  logic            q_bank;

  typedef struct packed {
    logic [7:0] data;
    logic       bank;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  typedef struct {
    logic        f;
    logic        d;
    logic        we;
    logic        wb;
    logic [2:0]  wa;
    logic        rb;
    logic [2:0]  ra;
    logic        dv;
    logic [11:0] lc;
  } vec_t;
  vec_t tbl[20];

  int   checks = 0;
  int   errors = 0;
  logic exp_bank;

  always #5 clk = ~clk;

  mirror_line_ctrl #(.LINE_W(LW), .AW(AWT), .LC_W(LCW)) dut (
    .iCCD_PIXCLK(clk),
    .iRST_N     (rst_n),
    .iCCD_DVAL  (dval),
    .iCCD_FVAL  (fval),
    .iMIRROR_EN (mir),
    .oWR_EN     (wr_en),
    .oWR_BANK   (wr_bank),
    .oWR_ADDR   (wr_addr),
    .oRD_BANK   (rd_bank),
    .oRD_ADDR   (rd_addr),
    .oDVAL      (odval),
    .oLINE_CNT  (line_cnt),
    .oOVF       (ovf)
  );

  // Two line banks with registered read, addressed by the controller.
  always @(posedge clk) begin
    if (wr_en === 1'b1) mem[{wr_bank, wr_addr}] <= pix;
    q      <= mem[{rd_bank, rd_addr}];
    q_bank <= rd_bank;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output-valid cycle must match the next expected pixel.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && odval === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious: got data %0d with no line pending", q);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_data", {24'd0, q}, {24'd0, mon_e.data});
        chk("sb_bank", {31'd0, q_bank}, {31'd0, mon_e.bank});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    fval = 1'b0;
    dval = 1'b0;
    step();
    fval = 1'b1;
    step();
    exp_bank = 1'b0;
  endtask

  task automatic push_line(input int tag, input logic rev, input logic bank);
    for (int i = 0; i < LW; i++) begin
      int idx;
      idx = rev ? (LW - 1 - i) : i;
      sb.push_back({8'(tag * 8 + idx), bank});
    end
  endtask

  task automatic run_line(input int tag, input bit push);
    for (int i = 0; i < LW; i++) begin
      dval = 1'b1;
      pix  = 8'(tag * 8 + i);
      step();
    end
    if (push) push_line(tag, mir, exp_bank);
    exp_bank = ~exp_bank;
  endtask

  function automatic vec_t mk(input logic f, input logic d, input logic we, input logic wb,
                              input int wa, input logic rb, input int ra, input logic dv,
                              input int lc);
    vec_t v;
    v.f = f; v.d = d; v.we = we; v.wb = wb; v.wa = 3'(wa);
    v.rb = rb; v.ra = 3'(ra); v.dv = dv; v.lc = 12'(lc);
    return v;
  endfunction

  initial begin
    // Mirrored line, one row per cycle: row 0 is the FVAL rise, rows 1..8 the pixels.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0, 0, 1'b0, 0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 5, 1'b0, 0, 1'b0, 0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 6, 1'b0, 0, 1'b0, 0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 7, 1'b0, 0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 6, 1'b1, 0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 5, 1'b1, 0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4, 1'b1, 0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 3, 1'b1, 0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 2, 1'b1, 0);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b1, 0);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 0);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0, 1'b1, 1);
    tbl[19] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0, 1);

    rst_n = 1'b0; dval = 1'b0; fval = 1'b0; mir = 1'b0; pix = 8'd0; exp_bank = 1'b0;
    @(negedge clk);
    chk("rst_wr_en",   {31'd0, wr_en},   32'd0);
    chk("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
    chk("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("rst_rd_bank", {31'd0, rd_bank}, 32'd0);
    chk("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("rst_dval",    {31'd0, odval},   32'd0);
    chk("rst_linecnt", {20'd0, line_cnt}, 32'd0);
    chk("rst_ovf",     {31'd0, ovf},     32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Table: mirrored single line.
    mir = 1'b1;
    for (int r = 0; r < 20; r++) begin
      fval = tbl[r].f;
      dval = tbl[r].d;
      pix  = 8'(96 + r - 1);
      @(negedge clk);
      chk("tbl_wr_en",   {31'd0, wr_en},    {31'd0, tbl[r].we});
      chk("tbl_wr_bank", {31'd0, wr_bank},  {31'd0, tbl[r].wb});
      chk("tbl_wr_addr", {29'd0, wr_addr},  {29'd0, tbl[r].wa});
      chk("tbl_rd_bank", {31'd0, rd_bank},  {31'd0, tbl[r].rb});
      chk("tbl_rd_addr", {29'd0, rd_addr},  {29'd0, tbl[r].ra});
      chk("tbl_dval",    {31'd0, odval},    {31'd0, tbl[r].dv});
      chk("tbl_linecnt", {20'd0, line_cnt}, {20'd0, tbl[r].lc});
      if (r == 8) push_line(12, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end

    // Straight readout; flipping the mirror input during the read must not alter order.
    frame_start();
    mir = 1'b0;
    run_line(1, 1'b1);
    dval = 1'b0;
    repeat (4) step();
    mir = 1'b1;
    repeat (12) step();
    mir = 1'b0;
    @(negedge clk);
    chk("straight_linecnt", {20'd0, line_cnt}, 32'd1);

    // Back-to-back lines, 24 continuous pixels.
    frame_start();
    mir = 1'b1;
    for (int k = 2; k < 5; k++) run_line(k, 1'b1);
    dval = 1'b0;
    repeat (22) step();
    @(negedge clk);
    chk("b2b_linecnt", {20'd0, line_cnt}, 32'd3);
    chk("b2b_ovf",     {31'd0, ovf},      32'd0);
    chk("b2b_wr_bank", {31'd0, wr_bank},  32'd1);
    chk("b2b_rd_bank", {31'd0, rd_bank},  32'd1);

    // Continuous straight lines: the reader loses one cycle per line, so line 9 meets a
    // same-cycle clear/set on bank 1 and line 10 finds bank 0 still full and is dropped.
    frame_start();
    mir = 1'b0;
    for (int k = 0; k < 10; k++) run_line(k, 1'b1);
    @(negedge clk);
    chk("ovf_same_cycle_clear", {31'd0, ovf}, 32'd0);
    run_line(8, 1'b0);
    dval = 1'b0;
    @(negedge clk);
    chk("ovf_set",         {31'd0, ovf},      32'd1);
    chk("ovf_linecnt_mid", {20'd0, line_cnt}, 32'd8);
    repeat (25) step();
    @(negedge clk);
    chk("ovf_linecnt_end", {20'd0, line_cnt}, 32'd10);
    chk("ovf_sticky",      {31'd0, ovf},      32'd1);
    frame_start();
    @(negedge clk);
    chk("ovf_cleared",      {31'd0, ovf},      32'd0);
    chk("linecnt_cleared",  {20'd0, line_cnt}, 32'd0);

    // Partial line followed by frame end and a new frame.
    frame_start();
    for (int i = 0; i < 5; i++) begin
      dval = 1'b1;
      pix  = 8'(200 + i);
      step();
    end
    dval = 1'b0;
    fval = 1'b0;
    repeat (15) step();
    @(negedge clk);
    chk("partial_hold_addr", {29'd0, wr_addr},  32'd5);
    chk("partial_no_dval",   {31'd0, odval},    32'd0);
    chk("partial_linecnt",   {20'd0, line_cnt}, 32'd0);
    fval = 1'b1;
    step();
    @(negedge clk);
    chk("partial_restart_addr", {29'd0, wr_addr}, 32'd0);
    chk("partial_restart_bank", {31'd0, wr_bank}, 32'd0);
    repeat (12) step();
    @(negedge clk);
    chk("partial_never_read", {20'd0, line_cnt}, 32'd0);

    // Asynchronous reset mid-read at rd_cnt = 4.
    frame_start();
    mir = 1'b1;
    run_line(5, 1'b1);
    dval = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("pre_rst_rd_addr", {29'd0, rd_addr}, 32'd3);
    chk("pre_rst_dval",    {31'd0, odval},   32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dval",    {31'd0, odval},   32'd0);
    chk("async_rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("async_rst_wr_bank", {31'd0, wr_bank}, 32'd0);
    sb.delete();
    fval = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    frame_start();
    run_line(6, 1'b1);
    dval = 1'b0;
    repeat (14) step();
    @(negedge clk);
    chk("post_rst_linecnt", {20'd0, line_cnt}, 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mirror_line_ctrl.md
Name: mirror_line_ctrl

Overview:
- Ping-pong scheduler for two line-buffer banks that sit in front of the column-mirror stage of the camera pipeline.
- Writes incoming pixel addresses into one bank while the previous complete line is read back from the other bank, in reversed or normal order.
- Sits between the CCD capture/demosaic output and the dual-bank line RAMs. It generates all RAM addresses, write enables, bank selects and the output data-valid.

Parameters:
- LINE_W, 640, pixels per line. Must be ≥ 2.
- AW, 10, address width. Requires 2^AW ≥ LINE_W.
- LC_W, 12, line-counter width.

Ports:
- iCCD_PIXCLK  in  1  pixel clock; all logic on its rising edge
- iRST_N  in  1  asynchronous active-low reset
- iCCD_DVAL  in  1  input pixel valid
- iCCD_FVAL  in  1  frame valid; a rising edge starts a frame
- iMIRROR_EN  in  1  1 = reversed readout, 0 = straight readout
- oWR_EN  out  1  RAM write enable; equals iCCD_DVAL & iCCD_FVAL, combinational
- oWR_BANK  out  1  bank currently being written
- oWR_ADDR  out  AW  write address, equal to wr_cnt
- oRD_BANK  out  1  bank currently being read
- oRD_ADDR  out  AW  read address
- oDVAL  out  1  output valid, aligned with RAM q (RAM has 1-cycle registered read)
- oLINE_CNT  out  LC_W  lines emitted this frame
- oOVF  out  1  sticky overflow flag

Behaviour:
- Reset state:
  - All counters, bank selects, full[1:0], oDVAL, oOVF and oLINE_CNT = 0.
  - Read FSM = IDLE.
  - The last sampled FVAL value = 0.
- Write side:
  - On each cycle with DVAL & FVAL: wr_cnt increments.
  - When wr_cnt == LINE_W-1 and DVAL & FVAL:
    - wr_cnt → 0 and oWR_BANK toggles.
    - If full[oWR_BANK] == 0: set full[oWR_BANK].
    - Otherwise: the line is dropped, full is unchanged, oOVF is set to 1.
- Read FSM:
  - IDLE: if full[rd_bank] == 1, go to READ, set rd_cnt = 0, and latch iMIRROR_EN into mir.
  - READ: oRD_ADDR = mir ? LINE_W-1-rd_cnt : rd_cnt. rd_cnt increments every cycle.
  - At rd_cnt == LINE_W-1: clear full[rd_bank], toggle rd_bank, increment oLINE_CNT (wraps at 2^LC_W), return to IDLE.
  - In IDLE, oRD_ADDR holds 0.
- oDVAL: (state == READ) delayed by 1 register.
- Latency:
  - The last write of a line occurs at edge T; full is set at T.
  - READ is entered at T+1; the first read address is presented during cycle T+1.
  - oDVAL = 1 from T+2 for exactly LINE_W cycles.
- Simultaneous clear and set on the same bank in one cycle: the clear is applied first, then the set. No overflow results.
- A change of iMIRROR_EN mid-line has no effect until the next line starts.
- Frame start (iCCD_FVAL 0→1, detected by a registered compare), applied synchronously:
  - wr_cnt, oWR_BANK, rd_bank, full, oLINE_CNT and oOVF all clear.
  - The FSM goes to IDLE, aborting any read in progress. oDVAL drops on the next cycle.
- Frame end:
  - FVAL low blocks writes.
  - A partial line (wr_cnt ≠ 0) is never marked full and is discarded at the next frame start.
  - A read already in progress completes.
- Asynchronous reset asserted mid-line: immediately returns every register to its reset value.

Test Plan (LINE_W = 8):
- Mirror line: FVAL rise, 8 consecutive DVAL, mirror = 1.
  - oWR_ADDR = 0..7 on bank 0.
  - Then oRD_BANK = 0 and oRD_ADDR = 7,6,…,0; oDVAL high 8 cycles starting 2 cycles after the last write.
  - oLINE_CNT = 1.
- Straight mode: same stimulus with mirror = 0 → oRD_ADDR = 0..7.
  - Additionally, toggling iMIRROR_EN at read cycle 3 does not change the order.
- Back-to-back lines: 24 continuous DVAL cycles.
  - Banks alternate 0,1,0; three reads complete; oOVF = 0; oLINE_CNT = 3.
- Overflow: force full[0] = 1 and hold the reader in READ on bank 1, then complete a line into bank 0.
  - oOVF = 1 and the line is dropped.
  - The next FVAL rise clears oOVF and oLINE_CNT to 0.
- Partial line: 5 DVAL, then FVAL low, then FVAL rise.
  - No read occurs (oDVAL stays 0).
  - wr_cnt restarts at 0 on bank 0.
- Reset during READ at rd_cnt = 4 → oDVAL = 0 and FSM IDLE immediately.
  - After release, a new 8-pixel line is processed normally.
